// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 sequential controller: instruction codes,
// architectural status codes, controller states and icode classification.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'd0;
  localparam logic [3:0] ICODE_NOP    = 4'd1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'd2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'd3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'd4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'd5;
  localparam logic [3:0] ICODE_OPQ    = 4'd6;
  localparam logic [3:0] ICODE_JXX    = 4'd7;
  localparam logic [3:0] ICODE_CALL   = 4'd8;
  localparam logic [3:0] ICODE_RET    = 4'd9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'd10;
  localparam logic [3:0] ICODE_POPQ   = 4'd11;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT
  } ctrl_state_e;

  // Instructions that touch data memory after EXECUTE.
  function automatic logic is_mem_icode(input logic [3:0] ic);
    case (ic)
      ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL,
      ICODE_RET, ICODE_PUSHQ, ICODE_POPQ:      return 1'b1;
      ICODE_HALT, ICODE_NOP, ICODE_RRMOVQ,
      ICODE_IRMOVQ, ICODE_OPQ, ICODE_JXX:      return 1'b0;
      default:                                 return 1'b0;
    endcase
  endfunction

  // Memory instructions that store (the rest of the memory group load).
  function automatic logic is_mem_write(input logic [3:0] ic);
    return (ic == ICODE_RMMOVQ) || (ic == ICODE_CALL) || (ic == ICODE_PUSHQ);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts data-memory wait cycles; o_expired flags the last permitted cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Wait counter: cleared outside MEMORY, advances on each cycle without ack.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle Y86 sequencing controller: walks each instruction through
// FETCH..PCUPD, handles data-memory waits/faults and stops in HALT.
module seq_ctrl
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_ack,
  input  logic             dmem_error,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             pc_en,
  output logic             set_cc,
  output logic             dmem_req,
  output logic             dmem_wr,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  ctrl_state_e      r_state;
  stat_e            r_stat;
  logic [3:0]       r_ir_icode;
  logic [CNT_W-1:0] r_retired;

  logic w_timer_clear;
  logic w_timer_en;
  logic w_timer_expired;

  assign w_timer_clear = (r_state != S_MEMORY);
  assign w_timer_en    = (r_state == S_MEMORY) && !dmem_ack;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_expired (w_timer_expired)
  );

  // Controller FSM: state, latched icode, architectural status, retire count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_stat     <= STAT_AOK;
      r_ir_icode <= ICODE_HALT;
      r_retired  <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir_icode <= icode;
          if (imem_error) begin
            r_stat  <= STAT_ADR;
            r_state <= S_HALT;
          end else if (!instr_valid) begin
            r_stat  <= STAT_INS;
            r_state <= S_HALT;
          end else begin
            r_state <= S_DECODE;
          end
        end
        S_DECODE:  r_state <= S_EXECUTE;
        S_EXECUTE: r_state <= is_mem_icode(r_ir_icode) ? S_MEMORY : S_WRITEBACK;
        S_MEMORY: begin
          // An ack on the final permitted cycle still completes the access.
          if (dmem_ack) begin
            if (dmem_error) begin
              r_stat  <= STAT_ADR;
              r_state <= S_HALT;
            end else begin
              r_state <= S_WRITEBACK;
            end
          end else if (w_timer_expired) begin
            r_stat  <= STAT_ADR;
            r_state <= S_HALT;
          end
        end
        S_WRITEBACK: r_state <= S_PCUPD;
        S_PCUPD: begin
          r_retired <= r_retired + CNT_W'(1);
          if (r_ir_icode == ICODE_HALT) begin
            r_stat  <= STAT_HLT;
            r_state <= S_HALT;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of state into enables; m_en is the only input-qualified output.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    f_en     = 1'b0;
    d_en     = 1'b0;
    e_en     = 1'b0;
    m_en     = 1'b0;
    w_en     = 1'b0;
    pc_en    = 1'b0;
    set_cc   = 1'b0;
    dmem_req = 1'b0;
    dmem_wr  = 1'b0;
    case (r_state)
      S_FETCH:   f_en = 1'b1;
      S_DECODE:  d_en = 1'b1;
      S_EXECUTE: begin
        e_en   = 1'b1;
        set_cc = (r_ir_icode == ICODE_OPQ);
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_wr  = is_mem_write(r_ir_icode);
        m_en     = dmem_ack;
      end
      S_WRITEBACK: w_en  = 1'b1;
      S_PCUPD:     pc_en = 1'b1;
      default:     ;
    endcase
  end

  assign stat    = r_stat;
  assign halted  = (r_state == S_HALT);
  assign retired = r_retired;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed self-checking bench for seq_ctrl.
// Output vector bit order: {f,d,e,m,w,pc,set_cc,dmem_req,dmem_wr}.
module tb_seq_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       icode;
  logic             instr_valid;
  logic             imem_error;
  logic             dmem_ack;
  logic             dmem_error;
  logic             f_en, d_en, e_en, m_en, w_en, pc_en;
  logic             set_cc, dmem_req, dmem_wr;
  logic [2:0]       stat;
  logic             halted;
  logic [CNT_W-1:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  seq_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .icode       (icode),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .dmem_ack    (dmem_ack),
    .dmem_error  (dmem_error),
    .f_en        (f_en),
    .d_en        (d_en),
    .e_en        (e_en),
    .m_en        (m_en),
    .w_en        (w_en),
    .pc_en       (pc_en),
    .set_cc      (set_cc),
    .dmem_req    (dmem_req),
    .dmem_wr     (dmem_wr),
    .stat        (stat),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] V_F   = 9'b100000000;
  localparam logic [8:0] V_D   = 9'b010000000;
  localparam logic [8:0] V_E   = 9'b001000000;
  localparam logic [8:0] V_ECC = 9'b001000100;
  localparam logic [8:0] V_MR  = 9'b000000010;
  localparam logic [8:0] V_MW  = 9'b000000011;
  localparam logic [8:0] V_W   = 9'b000010000;
  localparam logic [8:0] V_P   = 9'b000001000;
  localparam logic [8:0] V_OFF = 9'b000000000;

  function automatic logic [8:0] outs();
    return {f_en, d_en, e_en, m_en, w_en, pc_en, set_cc, dmem_req, dmem_wr};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after the reset-release edge: first cycle with reset high.
  task automatic do_reset();
    reset = 1'b0; icode = 4'd0; instr_valid = 1'b0; imem_error = 1'b0;
    dmem_ack = 1'b0; dmem_error = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (outs() !== V_F) begin
      n_errors++; $display("FAIL reset_enables: got %b expected %b", outs(), V_F);
    end
    n_checks++;
    if (stat !== 3'd1) begin
      n_errors++; $display("FAIL reset_stat: got %0d expected 1", stat);
    end
    n_checks++;
    if (retired !== '0 || halted !== 1'b0) begin
      n_errors++; $display("FAIL reset_counters: retired %0d halted %b expected 0 0", retired, halted);
    end
  endtask

  task automatic test_opq();
    logic [8:0] exp [5];
    exp = '{V_F, V_D, V_ECC, V_W, V_P};
    do_reset();
    icode = 4'd6; instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (outs() !== exp[i]) begin
        n_errors++; $display("FAIL opq_cycle%0d: got %b expected %b", i, outs(), exp[i]);
      end
      next_cycle();
    end
    #1;
    n_checks++;
    if (outs() !== V_F || retired !== 32'd1 || stat !== 3'd1) begin
      n_errors++;
      $display("FAIL opq_retire: got %b retired %0d stat %0d expected %b 1 1", outs(), retired, stat, V_F);
    end
  endtask

  task automatic test_mem_read_wait();
    logic [8:0] exp [9];
    logic       ack [9];
    exp = '{V_F, V_D, V_E, V_MR, V_MR, V_MR, V_MR | 9'b000100000, V_W, V_P};
    ack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    icode = 4'd5; instr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      dmem_ack = ack[i];
      #1;
      n_checks++;
      if (outs() !== exp[i]) begin
        n_errors++; $display("FAIL mrmovq_cycle%0d: got %b expected %b", i, outs(), exp[i]);
      end
      next_cycle();
    end
    dmem_ack = 1'b0;
    #1;
    n_checks++;
    if (outs() !== V_F || retired !== 32'd1) begin
      n_errors++; $display("FAIL mrmovq_retire: got %b retired %0d expected %b 1", outs(), retired, V_F);
    end
  endtask

  task automatic test_mem_timeout();
    logic [8:0] exp;
    do_reset();
    icode = 4'd10; instr_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      exp = (i == 0) ? V_F : (i == 1) ? V_D : (i == 2) ? V_E : V_MW;
      #1;
      n_checks++;
      if (outs() !== exp) begin
        n_errors++; $display("FAIL timeout_cycle%0d: got %b expected %b", i, outs(), exp);
      end
      next_cycle();
    end
    #1;
    n_checks++;
    if (outs() !== V_OFF || halted !== 1'b1 || stat !== 3'd3 || retired !== '0) begin
      n_errors++;
      $display("FAIL timeout_halt: got %b halted %b stat %0d retired %0d expected 0 1 3 0", outs(), halted, stat, retired);
    end
    next_cycle();
    dmem_ack = 1'b1;
    #1;
    n_checks++;
    if (outs() !== V_OFF || stat !== 3'd3 || halted !== 1'b1) begin
      n_errors++; $display("FAIL timeout_frozen: got %b stat %0d halted %b expected 0 3 1", outs(), stat, halted);
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_ack_last_cycle();
    logic [8:0] exp;
    do_reset();
    icode = 4'd9; instr_valid = 1'b1;
    for (int i = 0; i < 21; i++) begin
      dmem_ack = (i == 18);
      exp = (i == 0) ? V_F : (i == 1) ? V_D : (i == 2) ? V_E :
            (i < 18) ? V_MR : (i == 18) ? (V_MR | 9'b000100000) :
            (i == 19) ? V_W : V_P;
      #1;
      n_checks++;
      if (outs() !== exp) begin
        n_errors++; $display("FAIL lastack_cycle%0d: got %b expected %b", i, outs(), exp);
      end
      next_cycle();
    end
    dmem_ack = 1'b0;
    #1;
    n_checks++;
    if (stat !== 3'd1 || retired !== 32'd1) begin
      n_errors++; $display("FAIL lastack_retire: stat %0d retired %0d expected 1 1", stat, retired);
    end
  endtask

  task automatic test_mem_error();
    do_reset();
    icode = 4'd8; instr_valid = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    dmem_ack = 1'b1; dmem_error = 1'b1;
    #1;
    n_checks++;
    if (outs() !== (V_MW | 9'b000100000)) begin
      n_errors++; $display("FAIL memerr_ack: got %b expected %b", outs(), V_MW | 9'b000100000);
    end
    next_cycle();
    dmem_ack = 1'b0; dmem_error = 1'b0;
    #1;
    n_checks++;
    if (outs() !== V_OFF || stat !== 3'd3 || retired !== '0 || halted !== 1'b1) begin
      n_errors++;
      $display("FAIL memerr_halt: got %b stat %0d retired %0d halted %b expected 0 3 0 1", outs(), stat, retired, halted);
    end
  endtask

  task automatic test_fetch_faults();
    do_reset();
    icode = 4'd6; instr_valid = 1'b0;
    next_cycle();
    #1;
    n_checks++;
    if (stat !== 3'd4 || halted !== 1'b1 || outs() !== V_OFF || retired !== '0) begin
      n_errors++; $display("FAIL ins_fault: stat %0d halted %b outs %b expected 4 1 0", stat, halted, outs());
    end
    do_reset();
    imem_error = 1'b1; instr_valid = 1'b0;
    next_cycle();
    #1;
    n_checks++;
    if (stat !== 3'd3 || halted !== 1'b1) begin
      n_errors++; $display("FAIL imem_priority: stat %0d halted %b expected 3 1", stat, halted);
    end
    do_reset();
    imem_error = 1'b1; instr_valid = 1'b1;
    next_cycle();
    #1;
    n_checks++;
    if (stat !== 3'd3 || halted !== 1'b1) begin
      n_errors++; $display("FAIL imem_fault: stat %0d halted %b expected 3 1", stat, halted);
    end
  endtask

  task automatic test_halt_instr();
    logic [8:0] exp [5];
    exp = '{V_F, V_D, V_E, V_W, V_P};
    do_reset();
    icode = 4'd0; instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (outs() !== exp[i]) begin
        n_errors++; $display("FAIL halt_cycle%0d: got %b expected %b", i, outs(), exp[i]);
      end
      next_cycle();
    end
    #1;
    n_checks++;
    if (stat !== 3'd2 || halted !== 1'b1 || retired !== 32'd1 || outs() !== V_OFF) begin
      n_errors++;
      $display("FAIL halt_state: stat %0d halted %b retired %0d outs %b expected 2 1 1 0", stat, halted, retired, outs());
    end
    icode = 4'd6; dmem_ack = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    #1;
    n_checks++;
    if (stat !== 3'd2 || halted !== 1'b1 || retired !== 32'd1 || outs() !== V_OFF) begin
      n_errors++; $display("FAIL halt_frozen: stat %0d retired %0d outs %b expected 2 1 0", stat, retired, outs());
    end
    dmem_ack = 1'b0;
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    n_checks++;
    if (stat !== 3'd1 || retired !== '0 || outs() !== V_F || halted !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_reset: stat %0d retired %0d outs %b halted %b expected 1 0 %b 0", stat, retired, outs(), halted, V_F);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] prog [3];
    logic [8:0] exp;
    prog = '{4'd6, 4'd3, 4'd0};
    do_reset();
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      icode = prog[k];
      for (int i = 0; i < 5; i++) begin
        exp = (i == 0) ? V_F : (i == 1) ? V_D :
              (i == 2) ? ((prog[k] == 4'd6) ? V_ECC : V_E) :
              (i == 3) ? V_W : V_P;
        #1;
        n_checks++;
        if (outs() !== exp) begin
          n_errors++; $display("FAIL b2b_instr%0d_cycle%0d: got %b expected %b", k, i, outs(), exp);
        end
        next_cycle();
      end
    end
    #1;
    n_checks++;
    if (retired !== 32'd3 || stat !== 3'd2 || halted !== 1'b1) begin
      n_errors++; $display("FAIL b2b_final: retired %0d stat %0d halted %b expected 3 2 1", retired, stat, halted);
    end
  endtask

  task automatic test_reset_mid_memory();
    do_reset();
    icode = 4'd4; instr_valid = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    reset = 1'b0;
    #1;
    n_checks++;
    if (outs() !== V_MW) begin
      n_errors++; $display("FAIL midmem_before: got %b expected %b", outs(), V_MW);
    end
    next_cycle();
    reset = 1'b1; dmem_ack = 1'b1; icode = 4'd1;
    #1;
    n_checks++;
    if (outs() !== V_F || stat !== 3'd1 || retired !== '0) begin
      n_errors++; $display("FAIL midmem_after: got %b stat %0d expected %b 1", outs(), stat, V_F);
    end
    next_cycle();
    dmem_ack = 1'b0;
    #1;
    n_checks++;
    if (outs() !== V_D) begin
      n_errors++; $display("FAIL midmem_resume: got %b expected %b", outs(), V_D);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_opq();
    test_mem_read_wait();
    test_mem_timeout();
    test_ack_last_cycle();
    test_mem_error();
    test_fetch_faults();
    test_halt_instr();
    test_back_to_back();
    test_reset_mid_memory();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
